// File: rtl/calc1_add_responder.sv
// Two-operand command responder: accepts a command with operand 1, takes operand 2
// on the next cycle, computes in EXEC and presents a one-cycle registered response.
module calc1_add_responder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       cmd_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [1:0]       resp_out,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP2  = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  state_t           state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [1:0]       resp_q, resp_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   add_sum;
  logic [4:0]       shamt;
  logic [1:0]       exec_resp;
  logic [WIDTH-1:0] exec_data;

  assign add_sum = {1'b0, op1_q} + {1'b0, op2_q};
  assign shamt   = op2_q[4:0];

  // Result of the latched command; errors always report a zero data word.
  always_comb begin
    exec_resp = RESP_ERR;
    exec_data = '0;
    case (cmd_q)
      CMD_ADD: begin
        if (!add_sum[WIDTH]) begin
          exec_resp = RESP_OK;
          exec_data = add_sum[WIDTH-1:0];
        end
      end
      CMD_SUB: begin
        if (op2_q <= op1_q) begin
          exec_resp = RESP_OK;
          exec_data = op1_q - op2_q;
        end
      end
      CMD_SHL: begin
        exec_resp = RESP_OK;
        exec_data = op1_q << shamt;
      end
      CMD_SHR: begin
        exec_resp = RESP_OK;
        exec_data = op1_q >> shamt;
      end
      default: begin
        exec_resp = RESP_ERR;
        exec_data = '0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    resp_d  = RESP_NONE;
    data_d  = '0;
    case (state_q)
      IDLE: begin
        if (cmd_in != CMD_NOP) begin
          cmd_d   = cmd_in;
          op1_d   = data_in;
          state_d = OP2;
        end
      end
      OP2: begin
        op2_d   = data_in;
        state_d = EXEC;
      end
      EXEC: begin
        resp_d  = exec_resp;
        data_d  = exec_data;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= CMD_NOP;
      op1_q   <= '0;
      op2_q   <= '0;
      resp_q  <= RESP_NONE;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign resp_out = resp_q;
  assign data_out = data_q;
  assign busy     = busy_q;

endmodule
